// File: rtl/regbank_arbiter.sv
// Two-requester arbiter in front of a 2-entry register bank with a 1-cycle read latency.
// Grants are round-robin, and a requester can lock the grant for a bounded run of requests.
module regbank_arbiter #(
    parameter int WIDTH    = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_we,
    input  logic             a_idx,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic             a_lock,
    output logic             a_rsp_valid,
    output logic [WIDTH-1:0] a_rsp_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_we,
    input  logic             b_idx,
    input  logic [WIDTH-1:0] b_wdata,
    input  logic             b_lock,
    output logic             b_rsp_valid,
    output logic [WIDTH-1:0] b_rsp_data,
    output logic             bank_en,
    output logic             bank_wr_index,
    output logic             bank_rd_index,
    output logic [WIDTH-1:0] bank_d,
    input  logic [WIDTH-1:0] bank_q
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_RR     = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;          // 0 = A preferred, 1 = B preferred
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]    cnt_inc;
    logic             tag_vld_q, tag_vld_d;
    logic             tag_own_q, tag_own_d;
    logic             wr_index_q, wr_index_d;
    logic             rd_index_q, rd_index_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    logic             gnt_a, gnt_b;
    logic             acc_any, acc_lock, acc_we, acc_idx;
    logic [WIDTH-1:0] acc_wdata;
    logic             wr_acc, rd_acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RR;
            prio_q     <= 1'b0;
            lock_cnt_q <= '0;
            tag_vld_q  <= 1'b0;
            tag_own_q  <= 1'b0;
            wr_index_q <= 1'b0;
            rd_index_q <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_own_q  <= tag_own_d;
            wr_index_q <= wr_index_d;
            rd_index_q <= rd_index_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Grant decode; nothing is granted while reset is asserted
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RR: begin
                    if (a_valid && (!b_valid || !prio_q)) gnt_a = 1'b1;
                    else if (b_valid)                     gnt_b = 1'b1;
                end
                ST_LOCK_A: gnt_a = a_valid;
                ST_LOCK_B: gnt_b = b_valid;
                default: begin
                    gnt_a = 1'b0;
                    gnt_b = 1'b0;
                end
            endcase
        end
    end

    assign acc_any   = gnt_a | gnt_b;
    assign acc_lock  = gnt_b ? b_lock  : a_lock;
    assign acc_we    = gnt_b ? b_we    : a_we;
    assign acc_idx   = gnt_b ? b_idx   : a_idx;
    assign acc_wdata = gnt_b ? b_wdata : a_wdata;
    assign wr_acc    = acc_any & acc_we;
    assign rd_acc    = acc_any & ~acc_we;

    // Next-state: priority flips after every accept; a lock run ends on unlock, limit or owner idle
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;
        cnt_inc    = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CW'(1);
        case (state_q)
            ST_RR: begin
                if (acc_any) begin
                    prio_d = ~gnt_b;
                    if (acc_lock && LOCK_MAX > 1) begin
                        state_d    = gnt_b ? ST_LOCK_B : ST_LOCK_A;
                        lock_cnt_d = CW'(1);
                    end
                end
            end
            ST_LOCK_A, ST_LOCK_B: begin
                if (acc_any) lock_cnt_d = cnt_inc;
                if (!acc_any || !acc_lock || cnt_inc == CNT_MAX) begin
                    state_d    = ST_RR;
                    prio_d     = (state_q == ST_LOCK_A);
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RR;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Bank control and response routing
    always_comb begin
        tag_vld_d  = rd_acc;
        tag_own_d  = gnt_b;
        wr_index_d = wr_acc ? acc_idx   : wr_index_q;
        wr_data_d  = wr_acc ? acc_wdata : wr_data_q;
        rd_index_d = rd_acc ? acc_idx   : rd_index_q;
    end

    assign a_ready       = gnt_a;
    assign b_ready       = gnt_b;
    assign bank_en       = wr_acc;
    assign bank_wr_index = wr_index_d;
    assign bank_d        = wr_data_d;
    assign bank_rd_index = rd_index_d;

    // A tag in flight when reset hits must not produce a response
    assign a_rsp_valid = tag_vld_q & ~tag_own_q & ~rst;
    assign b_rsp_valid = tag_vld_q &  tag_own_q & ~rst;
    assign a_rsp_data  = a_rsp_valid ? bank_q : '0;
    assign b_rsp_data  = b_rsp_valid ? bank_q : '0;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed grant tables, hand sequences, and a randomized run
// against a transaction-level model of the arbitration rules and the register bank.
module tb_regbank_arbiter;
    localparam int WIDTH    = 32;
    localparam int LOCK_MAX = 4;
    localparam logic [31:0] C0 = 32'h0000_AAAA;
    localparam logic [31:0] C1 = 32'h5555_BBBB;

    logic clk = 1'b0;
    logic rst;
    logic a_valid, a_ready, a_we, a_idx, a_lock, a_rsp_valid;
    logic b_valid, b_ready, b_we, b_idx, b_lock, b_rsp_valid;
    logic [WIDTH-1:0] a_wdata, b_wdata, a_rsp_data, b_rsp_data;
    logic bank_en, bank_wr_index, bank_rd_index;
    logic [WIDTH-1:0] bank_d, bank_q;

    always #5 clk = ~clk;

    regbank_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_idx(a_idx),
        .a_wdata(a_wdata), .a_lock(a_lock), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_idx(b_idx),
        .b_wdata(b_wdata), .b_lock(b_lock), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .bank_en(bank_en), .bank_wr_index(bank_wr_index), .bank_rd_index(bank_rd_index),
        .bank_d(bank_d), .bank_q(bank_q)
    );

    // Register bank: 2 entries, reloaded with known contents on rst, registered read
    logic [31:0] mem [2];
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= C0;
            mem[1] <= C1;
        end else if (bank_en) begin
            mem[bank_wr_index] <= bank_d;
        end
        bank_q <= mem[bank_rd_index];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_we = 0; a_idx = 0; a_lock = 0; a_wdata = '0;
        b_valid = 0; b_we = 0; b_idx = 0; b_lock = 0; b_wdata = '0;
    endtask

    typedef struct {
        logic av, alock, aidx, bv, block, bidx, ea, eb;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic alock, input logic aidx,
                                input logic bv, input logic block, input logic bidx,
                                input logic ea, input logic eb);
        vec_t r;
        r.av = av; r.alock = alock; r.aidx = aidx;
        r.bv = bv; r.block = block; r.bidx = bidx;
        r.ea = ea; r.eb = eb;
        return r;
    endfunction

    // Transaction-level model state
    int          owner;      // -1 when no lock run, else 0 (A) / 1 (B)
    int          turn;       // requester preferred on contention
    int          held;       // grants taken in the current lock run
    logic        pv;
    int          pwho;
    logic [31:0] pdata;
    logic [31:0] regs [2];

    initial begin
        vec_t tbl[$];
        logic pend_v, pend_own, pend_idx;
        int   g;
        logic gw, gi, gl;
        logic [31:0] gd;

        rst = 1;
        idle_inputs();
        a_valid = 1;
        tick();
        tick();
        chk1("rst a_ready forced low", a_ready, 1'b0);
        chk1("rst b_ready", b_ready, 1'b0);
        chk1("rst bank_en", bank_en, 1'b0);
        chk32("rst bank_d", bank_d, 32'h0);
        chk1("rst bank_wr_index", bank_wr_index, 1'b0);
        chk1("rst bank_rd_index", bank_rd_index, 1'b0);
        chk1("rst a_rsp_valid", a_rsp_valid, 1'b0);
        chk1("rst b_rsp_valid", b_rsp_valid, 1'b0);
        chk32("rst a_rsp_data", a_rsp_data, 32'h0);
        rst = 0;
        idle_inputs();

        // contention: alternating grants
        repeat (2) begin
            tbl.push_back(mk(1,0,0, 1,0,1, 1,0));
            tbl.push_back(mk(1,0,0, 1,0,1, 0,1));
        end
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0));
        // lock 1,1,0 with B waiting
        tbl.push_back(mk(1,1,1, 1,0,0, 1,0));
        tbl.push_back(mk(1,1,0, 1,0,0, 1,0));
        tbl.push_back(mk(1,0,1, 1,0,0, 1,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 0,1));
        // lock limit: A keeps a_lock high
        repeat (4) tbl.push_back(mk(1,1,0, 1,0,1, 1,0));
        tbl.push_back(mk(1,1,0, 1,0,1, 0,1));
        // idle release
        tbl.push_back(mk(1,1,1, 1,0,0, 1,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 0,0));
        tbl.push_back(mk(1,0,0, 1,0,0, 0,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0));

        pend_v = 0; pend_own = 0; pend_idx = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            a_valid = tbl[i].av; a_lock = tbl[i].alock; a_idx = tbl[i].aidx; a_we = 0;
            b_valid = tbl[i].bv; b_lock = tbl[i].block; b_idx = tbl[i].bidx; b_we = 0;
            #1;
            chk1($sformatf("row%0d a_ready", i), a_ready, tbl[i].ea);
            chk1($sformatf("row%0d b_ready", i), b_ready, tbl[i].eb);
            chk1($sformatf("row%0d a_rsp_valid", i), a_rsp_valid, pend_v && !pend_own);
            chk1($sformatf("row%0d b_rsp_valid", i), b_rsp_valid, pend_v && pend_own);
            if (pend_v && !pend_own) chk32($sformatf("row%0d a_rsp_data", i), a_rsp_data, pend_idx ? C1 : C0);
            if (pend_v && pend_own)  chk32($sformatf("row%0d b_rsp_data", i), b_rsp_data, pend_idx ? C1 : C0);
            pend_v   = tbl[i].ea | tbl[i].eb;
            pend_own = tbl[i].eb;
            pend_idx = tbl[i].eb ? tbl[i].bidx : tbl[i].aidx;
            @(posedge clk);
            #1;
        end

        // write then read of the same index
        idle_inputs();
        a_valid = 1; a_we = 1; a_idx = 1; a_wdata = 32'hDEADBEEF;
        #1;
        chk1("wr a_ready", a_ready, 1'b1);
        chk1("wr bank_en", bank_en, 1'b1);
        chk1("wr bank_wr_index", bank_wr_index, 1'b1);
        chk32("wr bank_d", bank_d, 32'hDEADBEEF);
        tick();
        a_we = 0; a_wdata = 32'h0;
        #1;
        chk1("rd a_ready", a_ready, 1'b1);
        chk1("rd bank_en", bank_en, 1'b0);
        chk1("rd bank_rd_index", bank_rd_index, 1'b1);
        chk32("rd bank_d held", bank_d, 32'hDEADBEEF);
        tick();
        idle_inputs();
        #1;
        chk1("wr-rd a_rsp_valid", a_rsp_valid, 1'b1);
        chk32("wr-rd a_rsp_data", a_rsp_data, 32'hDEADBEEF);
        chk1("wr-rd b_rsp_valid", b_rsp_valid, 1'b0);
        tick();

        // reset while a read is in flight
        a_valid = 1; a_idx = 0;
        #1;
        chk1("rr a_ready", a_ready, 1'b1);
        tick();
        rst = 1; a_valid = 0; b_valid = 1;
        #1;
        chk1("rr a_rsp_valid t+1", a_rsp_valid, 1'b0);
        chk1("rr b_ready in rst", b_ready, 1'b0);
        chk1("rr bank_en", bank_en, 1'b0);
        tick();
        rst = 0; a_valid = 1;
        #1;
        chk1("rr a_rsp_valid t+2", a_rsp_valid, 1'b0);
        chk1("rr b_rsp_valid t+2", b_rsp_valid, 1'b0);
        chk1("rr grant A after rst", a_ready, 1'b1);
        chk1("rr B held off", b_ready, 1'b0);
        tick();

        // randomized run against the model
        owner = -1; turn = 0; held = 0; pv = 0; pwho = 0; pdata = '0;
        regs[0] = C0; regs[1] = C1;
        for (int i = 0; i < 600; i++) begin
            rst     = (i == 0) || ($urandom_range(0, 39) == 0);
            a_valid = ($urandom_range(0, 9) < 7);
            a_we    = 1'($urandom);
            a_idx   = 1'($urandom);
            a_lock  = ($urandom_range(0, 9) < 4);
            a_wdata = $urandom;
            b_valid = ($urandom_range(0, 9) < 7);
            b_we    = 1'($urandom);
            b_idx   = 1'($urandom);
            b_lock  = ($urandom_range(0, 9) < 4);
            b_wdata = $urandom;
            #1;
            g = -1;
            if (!rst) begin
                if (owner >= 0) begin
                    if (owner == 0 ? a_valid : b_valid) g = owner;
                end else if (a_valid && b_valid) g = turn;
                else if (a_valid) g = 0;
                else if (b_valid) g = 1;
            end
            gw = (g == 1) ? b_we    : a_we;
            gi = (g == 1) ? b_idx   : a_idx;
            gl = (g == 1) ? b_lock  : a_lock;
            gd = (g == 1) ? b_wdata : a_wdata;
            chk1("rnd a_ready", a_ready, g == 0);
            chk1("rnd b_ready", b_ready, g == 1);
            chk1("rnd bank_en", bank_en, (g >= 0) && gw);
            if (g >= 0 && gw) begin
                chk1("rnd bank_wr_index", bank_wr_index, gi);
                chk32("rnd bank_d", bank_d, gd);
            end
            if (g >= 0 && !gw) chk1("rnd bank_rd_index", bank_rd_index, gi);
            chk1("rnd a_rsp_valid", a_rsp_valid, !rst && pv && pwho == 0);
            chk1("rnd b_rsp_valid", b_rsp_valid, !rst && pv && pwho == 1);
            if (!rst && pv && pwho == 0) chk32("rnd a_rsp_data", a_rsp_data, pdata);
            if (!rst && pv && pwho == 1) chk32("rnd b_rsp_data", b_rsp_data, pdata);

            if (rst) begin
                owner = -1; turn = 0; held = 0; pv = 0;
                regs[0] = C0; regs[1] = C1;
            end else begin
                pv    = (g >= 0) && !gw;
                pwho  = g;
                pdata = regs[gi];
                if (g >= 0 && gw) regs[gi] = gd;
                if (g >= 0) begin
                    turn = 1 - g;
                    if (owner < 0) begin
                        if (gl && LOCK_MAX > 1) begin
                            owner = g;
                            held  = 1;
                        end
                    end else begin
                        held++;
                        if (!gl || held >= LOCK_MAX) owner = -1;
                    end
                end else if (owner >= 0) begin
                    turn  = 1 - owner;
                    owner = -1;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
